fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
Sequences the 16-bit combinational instruction ROM for the CPU. Owns the program counter and registers the IF/ID stage outputs. Handles decode/execute branch redirects, pipeline stalls and HALT (16'hFFFF) detection. Also arbitrates the single ROM address port between instruction fetch and a debug read port, with starvation protection for the debug side.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
HALT_WORD, 16'hFFFF, instruction encoding that stops fetch
PC_STEP, 2, byte increment per instruction
DBG_MAX_WAIT, 8, RUN cycles a debug request may wait before fetch is forced to give up one cycle

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
imem_addr  out  16  ROM address (combinational mux of pc / dbg_addr)
imem_data  in  16  ROM data, combinational from imem_addr
stall  in  1  hold IF/ID outputs and pc
redirect_valid  in  1  branch taken; load redirect_pc and flush
redirect_pc  in  16  branch target
resume  in  1  single-cycle pulse; leave HALT
dbg_req  in  1  debug read request, level, held until dbg_ack
dbg_addr  in  16  debug read address
dbg_ack  out  1  one-cycle pulse; dbg_data valid
dbg_data  out  16  ROM word read for debug
if_valid  out  1  if_instr is a real instruction
if_instr  out  16  fetched instruction
if_pc  out  16  address of if_instr
if_pc_next  out  16  if_pc + PC_STEP
halted  out  1  fetch stopped on HALT_WORD

Behaviour:
- Async reset clears everything immediately. pc=RESET_PC, state=BOOT, wait_cnt=0. All outputs go to 0: if_valid, if_instr, if_pc, if_pc_next, halted, dbg_ack, dbg_data. Any pending debug read is dropped; no ack is issued for it.
- States:
  - BOOT: one bubble cycle, then RUN.
  - RUN: normal fetch.
  - HALT: fetch stopped.
- Debug grant (dbg_gnt) is asserted when dbg_req=1, dbg_ack=0, and one of the following holds:
  - state is BOOT or HALT;
  - state is RUN and stall=1;
  - state is RUN and wait_cnt==DBG_MAX_WAIT (steal cycle).
- While dbg_gnt: imem_addr=dbg_addr; next edge dbg_data<=imem_data, dbg_ack<=1 for exactly one cycle, wait_cnt<=0. Otherwise imem_addr=pc.
- wait_cnt increments each RUN cycle with dbg_req=1 and no grant. It saturates at DBG_MAX_WAIT and clears when the grant is issued.
- RUN, priority order at each edge:
  1. redirect_valid: pc<=redirect_pc, if_valid<=0, if_instr<=0. Stall is ignored. This also applies in a steal cycle.
  2. steal cycle: pc holds, if_valid<=0.
  3. stall: pc and all if_* hold.
  4. otherwise: if_instr<=imem_data, if_pc<=pc, if_pc_next<=pc+PC_STEP, if_valid<=1.
     - If imem_data==HALT_WORD: pc holds, state<=HALT, halted<=1.
     - Else: pc<=pc+PC_STEP.
- HALT:
  - Not stalled: if_valid<=0. Stalled: if_* hold, so the HALT word is delivered exactly once.
  - redirect_valid is ignored.
  - resume=1: pc<=pc+PC_STEP, halted<=0, state<=RUN.
- Arithmetic: pc+PC_STEP is 16-bit modulo; 16'hFFFE wraps to 16'h0000.
- Odd addresses (redirect or debug) pass through unmodified.
- A stalled fetch of HALT_WORD neither latches nor enters HALT.

Decomposition:
- Shared package cpu_pkg holds:
  - WORD_W=16, RESET_PC, HALT_WORD, PC_STEP;
  - the fetch_state_t enum {BOOT, RUN, HALT}.
- One sub-module, fetch_dbg_arbiter, contains the dbg_gnt logic, the wait_cnt saturating counter and the dbg_ack/dbg_data registers.
- The pc/IF register file and FSM stay in the top module.

Test Plan:
- Reset release, no stall, program ROM loaded:
  - cycle 1 after release is the BOOT bubble (if_valid=0);
  - then if_pc/if_instr = 0000/0120, 0002/0121, 0004/23FF on consecutive cycles;
  - if_pc_next = if_pc+2.
- Run to 0x0036 holding FFFF:
  - if_valid=1, if_instr=FFFF for one cycle; halted=1; if_valid=0 afterwards;
  - resume pulse -> next fetch if_pc=0038, if_instr=0000.
- redirect_valid with redirect_pc=0024 while pc=001C:
  - next cycle if_valid=0;
  - following cycle if_pc=0024, if_instr=0110.
- stall held 3 cycles at if_pc=0008 (0564):
  - if_* unchanged for all 3 cycles;
  - fetch resumes at 000A/0158.
- dbg_req with dbg_addr=0014 in RUN, no stall:
  - dbg_ack after 8 wait cycles plus 1 steal cycle, dbg_data=8694;
  - the steal cycle shows if_valid=0 and pc unchanged.
- Same request while HALT:
  - dbg_ack on the next edge, dbg_data=8694.
- rst_n low while dbg_req pending:
  - all outputs 0 immediately;
  - no dbg_ack issued until a new request after reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants, fetch FSM state type and PC arithmetic helper.
package cpu_pkg;

   localparam int WORD_W = 16;
   localparam logic [WORD_W-1:0] RESET_PC  = 16'h0000;
   localparam logic [WORD_W-1:0] HALT_WORD = 16'hFFFF;
   localparam logic [WORD_W-1:0] PC_STEP   = 16'd2;

   localparam int DBG_MAX_WAIT = 8;
   localparam int WAIT_W       = $clog2(DBG_MAX_WAIT + 1);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   // Modulo 2^16: 16'hFFFE steps to 16'h0000.
   function automatic logic [WORD_W-1:0] pc_inc(input logic [WORD_W-1:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// ROM port, pipeline control, debug read port and IF/ID stage outputs of the fetch unit.
interface fetch_controller_if;
   import cpu_pkg::*;

   logic [WORD_W-1:0] imem_addr;
   logic [WORD_W-1:0] imem_data;
   logic              stall;
   logic              redirect_valid;
   logic [WORD_W-1:0] redirect_pc;
   logic              resume;
   logic              dbg_req;
   logic [WORD_W-1:0] dbg_addr;
   logic              dbg_ack;
   logic [WORD_W-1:0] dbg_data;
   logic              if_valid;
   logic [WORD_W-1:0] if_instr;
   logic [WORD_W-1:0] if_pc;
   logic [WORD_W-1:0] if_pc_next;
   logic              halted;

   modport master (
      output imem_addr,
      input  imem_data,
      input  stall, redirect_valid, redirect_pc, resume,
      input  dbg_req, dbg_addr,
      output dbg_ack, dbg_data,
      output if_valid, if_instr, if_pc, if_pc_next, halted
   );

   modport slave (
      input  imem_addr,
      output imem_data,
      output stall, redirect_valid, redirect_pc, resume,
      output dbg_req, dbg_addr,
      input  dbg_ack, dbg_data,
      input  if_valid, if_instr, if_pc, if_pc_next, halted
   );

endinterface

// File: rtl/fetch_dbg_arbiter.sv
// Grants the ROM port to debug reads when fetch is idle/stalled, or steals one RUN cycle after
// DBG_MAX_WAIT ungranted cycles; ack/data are registered one edge after the grant.
module fetch_dbg_arbiter
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  fetch_state_t      i_state,
   input  logic              i_stall,
   input  logic              i_dbg_req,
   input  logic [WORD_W-1:0] i_imem_data,
   output logic              o_dbg_gnt,
   output logic              o_steal,
   output logic              o_dbg_ack,
   output logic [WORD_W-1:0] o_dbg_data
);

   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DBG_MAX_WAIT);

   logic [WAIT_W-1:0] r_wait_cnt;
   logic              r_dbg_ack;
   logic [WORD_W-1:0] r_dbg_data;
   logic              w_run;
   logic              w_pending;

   // The request stays high during its own ack cycle; masking by ack avoids a double read.
   assign w_run     = (i_state == RUN);
   assign w_pending = i_dbg_req && !r_dbg_ack;
   assign o_steal   = w_pending && w_run && (r_wait_cnt == WAIT_MAX);
   assign o_dbg_gnt = w_pending && (!w_run || i_stall || o_steal);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
         r_dbg_ack  <= 1'b0;
         r_dbg_data <= '0;
      end else begin
         r_dbg_ack <= o_dbg_gnt;
         if (o_dbg_gnt) begin
            r_dbg_data <= i_imem_data;
            r_wait_cnt <= '0;
         end else if (w_run && i_dbg_req && (r_wait_cnt != WAIT_MAX)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
      end
   end

   assign o_dbg_ack  = r_dbg_ack;
   assign o_dbg_data = r_dbg_data;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch: PC, BOOT/RUN/HALT FSM and registered IF/ID outputs, one-cycle ROM-to-IF latency.
// Stall holds PC and IF/ID; redirect flushes; debug reads share the ROM port via fetch_dbg_arbiter.
module fetch_controller
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   fetch_controller_if.master bus
);

   fetch_state_t      r_state, w_state_nxt;
   logic [WORD_W-1:0] r_pc, w_pc_nxt;
   logic              r_if_valid, w_if_valid_nxt;
   logic [WORD_W-1:0] r_if_instr, w_if_instr_nxt;
   logic [WORD_W-1:0] r_if_pc, w_if_pc_nxt;
   logic [WORD_W-1:0] r_if_pc_next, w_if_pc_next_nxt;
   logic              r_halted, w_halted_nxt;
   logic              w_dbg_gnt;
   logic              w_steal;

   fetch_dbg_arbiter u_dbg_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_state     (r_state),
      .i_stall     (bus.stall),
      .i_dbg_req   (bus.dbg_req),
      .i_imem_data (bus.imem_data),
      .o_dbg_gnt   (w_dbg_gnt),
      .o_steal     (w_steal),
      .o_dbg_ack   (bus.dbg_ack),
      .o_dbg_data  (bus.dbg_data)
   );

   assign bus.imem_addr = w_dbg_gnt ? bus.dbg_addr : r_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= BOOT;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_if_valid_nxt   = r_if_valid;
      w_if_instr_nxt   = r_if_instr;
      w_if_pc_nxt      = r_if_pc;
      w_if_pc_next_nxt = r_if_pc_next;
      w_halted_nxt     = r_halted;
      case (r_state)
         BOOT: w_state_nxt = RUN;
         RUN: begin
            if (bus.redirect_valid) begin
               w_pc_nxt       = bus.redirect_pc;
               w_if_valid_nxt = 1'b0;
               w_if_instr_nxt = '0;
            end else if (w_steal) begin
               w_if_valid_nxt = 1'b0;
            end else if (!bus.stall) begin
               w_if_instr_nxt   = bus.imem_data;
               w_if_pc_nxt      = r_pc;
               w_if_pc_next_nxt = pc_inc(r_pc);
               w_if_valid_nxt   = 1'b1;
               // PC parks on the HALT word so resume continues right after it.
               if (bus.imem_data == HALT_WORD) begin
                  w_state_nxt  = HALT;
                  w_halted_nxt = 1'b1;
               end else begin
                  w_pc_nxt = pc_inc(r_pc);
               end
            end
         end
         HALT: begin
            if (!bus.stall) w_if_valid_nxt = 1'b0;
            if (bus.resume) begin
               w_pc_nxt     = pc_inc(r_pc);
               w_halted_nxt = 1'b0;
               w_state_nxt  = RUN;
            end
         end
         default: w_state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc         <= RESET_PC;
         r_if_valid   <= 1'b0;
         r_if_instr   <= '0;
         r_if_pc      <= '0;
         r_if_pc_next <= '0;
         r_halted     <= 1'b0;
      end else begin
         r_pc         <= w_pc_nxt;
         r_if_valid   <= w_if_valid_nxt;
         r_if_instr   <= w_if_instr_nxt;
         r_if_pc      <= w_if_pc_nxt;
         r_if_pc_next <= w_if_pc_next_nxt;
         r_halted     <= w_halted_nxt;
      end
   end

   assign bus.if_valid   = r_if_valid;
   assign bus.if_instr   = r_if_instr;
   assign bus.if_pc      = r_if_pc;
   assign bus.if_pc_next = r_if_pc_next;
   assign bus.halted     = r_halted;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed program walk plus randomized stall/redirect/resume/debug traffic against a reference model.
module tb_fetch_controller;
   import cpu_pkg::*;

   localparam int S_BOOT = 0;
   localparam int S_RUN  = 1;
   localparam int S_HALT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = 16'h0;
   logic        resume = 1'b0;
   logic        dbg_req = 1'b0;
   logic [15:0] dbg_addr = 16'h0;
   logic        chk_en = 1'b0;

   logic [15:0] rom [0:65535];

   int n_vec = 0;
   int n_err = 0;

   fetch_controller_if bus ();

   assign bus.stall          = stall;
   assign bus.redirect_valid = redirect_valid;
   assign bus.redirect_pc    = redirect_pc;
   assign bus.resume         = resume;
   assign bus.dbg_req        = dbg_req;
   assign bus.dbg_addr       = dbg_addr;
   assign bus.imem_data      = rom[bus.imem_addr];

   fetch_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: architectural state only.
   int          m_st;
   int          m_wait;
   logic [15:0] m_pc, m_instr, m_ipc, m_ipcn, m_dat;
   logic        m_valid, m_halt, m_ack;

   function automatic logic steal_now();
      return dbg_req && !m_ack && (m_st == S_RUN) && (m_wait == DBG_MAX_WAIT);
   endfunction

   function automatic logic gnt_now();
      return dbg_req && !m_ack && ((m_st != S_RUN) || stall || steal_now());
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st <= S_BOOT; m_wait <= 0; m_pc <= 16'h0000;
         m_valid <= 1'b0; m_instr <= 16'h0; m_ipc <= 16'h0; m_ipcn <= 16'h0;
         m_halt <= 1'b0; m_ack <= 1'b0; m_dat <= 16'h0;
      end else begin
         m_ack <= gnt_now();
         if (gnt_now()) begin
            m_dat  <= rom[dbg_addr];
            m_wait <= 0;
         end else if (m_st == S_RUN && dbg_req && m_wait < DBG_MAX_WAIT) begin
            m_wait <= m_wait + 1;
         end
         if (m_st == S_BOOT) begin
            m_st <= S_RUN;
         end else if (m_st == S_RUN) begin
            if (redirect_valid) begin
               m_pc <= redirect_pc; m_valid <= 1'b0; m_instr <= 16'h0;
            end else if (steal_now()) begin
               m_valid <= 1'b0;
            end else if (!stall) begin
               m_instr <= rom[m_pc]; m_ipc <= m_pc; m_ipcn <= 16'(m_pc + 16'd2); m_valid <= 1'b1;
               if (rom[m_pc] == 16'hFFFF) begin
                  m_st <= S_HALT; m_halt <= 1'b1;
               end else begin
                  m_pc <= 16'(m_pc + 16'd2);
               end
            end
         end else begin
            if (!stall) m_valid <= 1'b0;
            if (resume) begin
               m_pc <= 16'(m_pc + 16'd2); m_halt <= 1'b0; m_st <= S_RUN;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("imem_addr",  bus.imem_addr, gnt_now() ? dbg_addr : m_pc);
         chk("if_valid",   16'(bus.if_valid), 16'(m_valid));
         chk("if_instr",   bus.if_instr, m_instr);
         chk("if_pc",      bus.if_pc, m_ipc);
         chk("if_pc_next", bus.if_pc_next, m_ipcn);
         chk("halted",     16'(bus.halted), 16'(m_halt));
         chk("dbg_ack",    16'(bus.dbg_ack), 16'(m_ack));
         chk("dbg_data",   bus.dbg_data, m_dat);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic exp_if(input string nm, input logic v, input logic [15:0] pc, input logic [15:0] ins);
      chk({nm, ".valid"}, 16'(bus.if_valid), 16'(v));
      chk({nm, ".pc"}, bus.if_pc, pc);
      chk({nm, ".instr"}, bus.if_instr, ins);
   endtask

   task automatic exp_all_zero(input string nm);
      chk({nm, ".if_valid"}, 16'(bus.if_valid), 16'h0);
      chk({nm, ".if_instr"}, bus.if_instr, 16'h0);
      chk({nm, ".if_pc"}, bus.if_pc, 16'h0);
      chk({nm, ".if_pc_next"}, bus.if_pc_next, 16'h0);
      chk({nm, ".halted"}, 16'(bus.halted), 16'h0);
      chk({nm, ".dbg_ack"}, 16'(bus.dbg_ack), 16'h0);
      chk({nm, ".dbg_data"}, bus.dbg_data, 16'h0);
   endtask

   task automatic rand_cycle();
      if (dbg_req && bus.dbg_ack) begin
         dbg_req = 1'b0;
      end else if (!dbg_req && !bus.dbg_ack && $urandom_range(0, 5) == 0) begin
         dbg_req  = 1'b1;
         dbg_addr = 16'($urandom);
      end
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      resume         = ($urandom_range(0, 5) == 0);
      step();
   endtask

   initial begin
      logic [15:0] w;
      for (int a = 0; a < 65536; a++) begin
         w = 16'($urandom);
         if ($urandom_range(0, 39) == 0) w = 16'hFFFF;
         else if (w == 16'hFFFF)         w = 16'h0000;
         rom[16'(a)] = w;
      end
      for (int a = 0; a <= 16'h003A; a++) rom[16'(a)] = 16'(16'h1000 + a);
      rom[16'h0000] = 16'h0120; rom[16'h0002] = 16'h0121; rom[16'h0004] = 16'h23FF;
      rom[16'h0008] = 16'h0564; rom[16'h000A] = 16'h0158; rom[16'h0014] = 16'h8694;
      rom[16'h0024] = 16'h0110; rom[16'h0036] = 16'hFFFF; rom[16'h0038] = 16'h0000;

      step(); step();
      chk_en = 1'b1;
      exp_all_zero("reset");
      rst_n = 1'b1;

      step(); exp_if("boot", 1'b0, 16'h0000, 16'h0000);
      step(); exp_if("f0", 1'b1, 16'h0000, 16'h0120);
      chk("f0.pc_next", bus.if_pc_next, 16'h0002);
      step(); exp_if("f1", 1'b1, 16'h0002, 16'h0121);
      step(); exp_if("f2", 1'b1, 16'h0004, 16'h23FF);
      chk("f2.pc_next", bus.if_pc_next, 16'h0006);
      step();
      step(); exp_if("f4", 1'b1, 16'h0008, 16'h0564);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(); exp_if("stall", 1'b1, 16'h0008, 16'h0564);
      end
      stall = 1'b0;
      step(); exp_if("unstall", 1'b1, 16'h000A, 16'h0158);

      repeat (8) step();
      exp_if("pre_redir", 1'b1, 16'h001A, rom[16'h001A]);
      redirect_valid = 1'b1; redirect_pc = 16'h0024;
      step(); exp_if("flush", 1'b0, 16'h001A, 16'h0000);
      redirect_valid = 1'b0;
      step(); exp_if("target", 1'b1, 16'h0024, 16'h0110);

      dbg_req = 1'b1; dbg_addr = 16'h0014;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("dbg_wait.ack", 16'(bus.dbg_ack), 16'h0);
         chk("dbg_wait.valid", 16'(bus.if_valid), 16'h1);
      end
      step();
      chk("steal.ack", 16'(bus.dbg_ack), 16'h1);
      chk("steal.data", bus.dbg_data, 16'h8694);
      chk("steal.valid", 16'(bus.if_valid), 16'h0);
      dbg_req = 1'b0;
      step(); exp_if("halt_word", 1'b1, 16'h0036, 16'hFFFF);
      chk("halt_word.halted", 16'(bus.halted), 16'h1);
      chk("halt_word.ack", 16'(bus.dbg_ack), 16'h0);
      step(); chk("halt.valid", 16'(bus.if_valid), 16'h0);

      dbg_req = 1'b1;
      step();
      chk("halt_dbg.ack", 16'(bus.dbg_ack), 16'h1);
      chk("halt_dbg.data", bus.dbg_data, 16'h8694);
      dbg_req = 1'b0;
      step(); chk("halt_dbg.ack_once", 16'(bus.dbg_ack), 16'h0);
      resume = 1'b1;
      step(); resume = 1'b0;
      chk("resume.halted", 16'(bus.halted), 16'h0);
      step(); exp_if("post_resume", 1'b1, 16'h0038, 16'h0000);
      chk("post_resume.pc_next", bus.if_pc_next, 16'h003A);

      for (int i = 0; i < 4000; i++) begin
         if (i == 2000) begin
            if (dbg_req) begin
               while (!bus.dbg_ack) step();
               dbg_req = 1'b0;
               step();
            end
            stall = 1'b0; redirect_valid = 1'b0; resume = 1'b0;
            dbg_req = 1'b1; dbg_addr = 16'h0014;
            step();
            rst_n = 1'b0;
            #1;
            exp_all_zero("async_rst");
            dbg_req = 1'b0;
            step(); step();
            rst_n = 1'b1;
            step();
            chk("post_rst.ack", 16'(bus.dbg_ack), 16'h0);
         end
         rand_cycle();
      end

      redirect_valid = 1'b0; stall = 1'b0; resume = 1'b0; dbg_req = 1'b0;
      step();
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
